// File: rtl/arb_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter:
// FSM state encoding, requester count and one-hot to index conversion.
package arb_pkg;

    localparam int unsigned NREQ  = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned ST_W  = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t GRANT   = 2'd1;
    localparam state_t RELEASE = 2'd2;

    // OR of the indices of all set bits; exact for a one-hot or zero input.
    function automatic logic [IDX_W-1:0] onehot2idx16(input logic [NREQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sixteen_ff.sv
// Lowest-index-first one-hot selector over 16 request bits.
// Purely combinational; the output is zero when no bit is set.
module sixteen_ff
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] sel_c_o
);

    assign sel_c_o = req_i & (~req_i + NREQ'(1));

endmodule

// File: rtl/rr_arb16.sv
// Sixteen-requester round-robin arbiter with grant hold, done-handshake release
// and hold timeout. All outputs are registered.
module rr_arb16
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 255,
    parameter int unsigned CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout,
    output logic [IDX_W-1:0] timeout_idx
);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              gnt_vld_q, gnt_vld_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W-1:0]  timeout_idx_q, timeout_idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]   elig_c, above_c, hi_c, sel_hi_c, sel_all_c, winner_c;
    logic [IDX_W-1:0]  win_idx_c;
    logic              drop_c, hold_end_c, release_c;

    // Rotated priority: requesters strictly above the last winner go first.
    assign elig_c    = req & ~mask;
    assign above_c   = ~((NREQ'(2) << ptr_q) - NREQ'(1));
    assign hi_c      = elig_c & above_c;
    assign winner_c  = (|hi_c) ? sel_hi_c : sel_all_c;
    assign win_idx_c = onehot2idx16(winner_c);

    sixteen_ff u_ff_hi (
        .req_i   (hi_c),
        .sel_c_o (sel_hi_c)
    );

    sixteen_ff u_ff_all (
        .req_i   (elig_c),
        .sel_c_o (sel_all_c)
    );

    assign drop_c     = ~req[gnt_idx_q];
    assign hold_end_c = (cnt_q == CNT_W'(HOLD_MAX - 1));
    assign release_c  = done | drop_c | hold_end_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|elig_c) state_d = GRANT;
            GRANT:   if (release_c) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d         = gnt_q;
        gnt_vld_d     = gnt_vld_q;
        gnt_idx_d     = gnt_idx_q;
        timeout_d     = 1'b0;
        timeout_idx_d = timeout_idx_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (|elig_c) begin
                    gnt_d     = winner_c;
                    gnt_vld_d = 1'b1;
                    gnt_idx_d = win_idx_c;
                    ptr_d     = win_idx_c;
                    cnt_d     = '0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    gnt_idx_d = '0;
                    // A handshake or dropped request in the same cycle wins over the timeout.
                    if (!done && !drop_c) begin
                        timeout_d     = 1'b1;
                        timeout_idx_d = gnt_idx_q;
                    end
                end else if (cnt_q != CNT_W'(HOLD_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                gnt_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q         <= '0;
            gnt_vld_q     <= 1'b0;
            gnt_idx_q     <= '0;
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
            ptr_q         <= IDX_W'(NREQ - 1);
            cnt_q         <= '0;
        end else begin
            gnt_q         <= gnt_d;
            gnt_vld_q     <= gnt_vld_d;
            gnt_idx_q     <= gnt_idx_d;
            timeout_q     <= timeout_d;
            timeout_idx_q <= timeout_idx_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_vld     = gnt_vld_q;
    assign gnt_idx     = gnt_idx_q;
    assign timeout     = timeout_q;
    assign timeout_idx = timeout_idx_q;

endmodule

// File: tb/tb_rr_arb16.sv
// Bench for rr_arb16: cycle-level reference model compared every cycle,
// plus directed scenarios with hand-computed grant sequences.
module tb_rr_arb16;

    localparam int unsigned HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] mask;
    logic        done;
    logic [15:0] gnt;
    logic        gnt_vld;
    logic [3:0]  gnt_idx;
    logic        timeout;
    logic [3:0]  timeout_idx;

    int checks = 0;
    int errors = 0;

    rr_arb16 #(.HOLD_MAX(HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mask        (mask),
        .done        (done),
        .gnt         (gnt),
        .gnt_vld     (gnt_vld),
        .gnt_idx     (gnt_idx),
        .timeout     (timeout),
        .timeout_idx (timeout_idx)
    );

    always #5 clk = ~clk;

    // Reference model: owner of the resource, cycles it has held it, bubble flag.
    int   m_owner;
    int   m_last;
    int   m_held;
    bit   m_bubble;
    bit   m_to;
    int   m_to_idx;

    function automatic int next_winner(input logic [15:0] elig, input int last);
        for (int k = 1; k <= 16; k++) begin
            if (elig[(last + k) % 16]) return (last + k) % 16;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner  <= -1;
            m_last   <= 15;
            m_held   <= 0;
            m_bubble <= 1'b0;
            m_to     <= 1'b0;
            m_to_idx <= 0;
        end else begin
            m_to <= 1'b0;
            if (m_owner >= 0) begin
                if (done || !req[4'(m_owner)] || (m_held + 1 >= int'(HOLD))) begin
                    if (!done && req[4'(m_owner)]) begin
                        m_to     <= 1'b1;
                        m_to_idx <= m_owner;
                    end
                    m_owner  <= -1;
                    m_bubble <= 1'b1;
                end else begin
                    m_held <= m_held + 1;
                end
            end else if (m_bubble) begin
                m_bubble <= 1'b0;
            end else if ((req & ~mask) != 16'h0) begin
                m_owner <= next_winner(req & ~mask, m_last);
                m_last  <= next_winner(req & ~mask, m_last);
                m_held  <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [15:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        chk("cyc_gnt", 32'(gnt), 32'(e_gnt));
        chk("cyc_vld", 32'(gnt_vld), 32'(m_owner >= 0));
        chk("cyc_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("cyc_to", 32'(timeout), 32'(m_to));
        chk("cyc_to_idx", 32'(timeout_idx), 32'(m_to_idx));
    end

    task automatic wait_grant(input int exp, input string nm, output int n);
        n = 0;
        while (!gnt_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_seen"}, 32'(gnt_vld), 32'd1);
        chk(nm, 32'(gnt_idx), 32'(exp));
        chk({nm, "_oh"}, 32'(gnt), 32'(16'd1 << exp));
        chk({nm, "_model"}, 32'(m_owner), 32'(exp));
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic do_reset(input logic [15:0] r, input logic [15:0] m);
        rst_n = 1'b0;
        req   = r;
        mask  = m;
        done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int hold;
        int cnt[16];

        rst_n = 1'b0;
        req   = '0;
        mask  = '0;
        done  = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_to_idx", 32'(timeout_idx), 32'd0);

        // Two requesters at the extremes alternate 0,15,0 with a 3-cycle period.
        do_reset(16'h8001, 16'h0);
        wait_grant(0, "t1_g0", n);
        chk("t1_lat", 32'(n), 32'd1);
        pulse_done();
        wait_grant(15, "t1_g15", n);
        chk("t1_period_a", 32'(n + 1), 32'd3);
        pulse_done();
        wait_grant(0, "t1_g0b", n);
        chk("t1_period_b", 32'(n + 1), 32'd3);

        // Full request set rotates through every index once.
        do_reset(16'hFFFF, 16'h0);
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        for (int i = 0; i < 17; i++) begin
            wait_grant(i % 16, "t2_rot", n);
            if (i < 16) cnt[gnt_idx]++;
            pulse_done();
        end
        for (int i = 0; i < 16; i++) chk("t2_once", 32'(cnt[i]), 32'd1);

        // Single requester never releases: hold limit, timeout pulse, regrant.
        do_reset(16'h0010, 16'h0);
        wait_grant(4, "t3_g4", n);
        hold = 1;
        n = 0;
        while (gnt_vld && n < 20) begin
            @(negedge clk);
            n++;
            if (gnt_vld) hold++;
        end
        chk("t3_hold", 32'(hold), 32'(HOLD));
        chk("t3_to", 32'(timeout), 32'd1);
        chk("t3_to_idx", 32'(timeout_idx), 32'd4);
        @(negedge clk);
        chk("t3_to_pulse", 32'(timeout), 32'd0);
        chk("t3_bubble", 32'(gnt_vld), 32'd0);
        wait_grant(4, "t3_regrant", n);
        chk("t3_regrant_lat", 32'(n), 32'd1);
        chk("t3_to_idx_held", 32'(timeout_idx), 32'd4);

        // Holder drops its request: release without timeout, next goes to idx7.
        do_reset(16'h0088, 16'h0);
        wait_grant(3, "t4_g3", n);
        @(negedge clk);
        req = 16'h0080;
        @(negedge clk);
        chk("t4_clear", 32'(gnt_vld), 32'd0);
        chk("t4_no_to", 32'(timeout), 32'd0);
        wait_grant(7, "t4_g7", n);

        // Masking the holder keeps its grant; idx1 is skipped afterwards.
        do_reset(16'h0006, 16'h0);
        wait_grant(1, "t5_g1", n);
        mask = 16'h0002;
        @(negedge clk);
        @(negedge clk);
        chk("t5_keep", 32'(gnt_idx), 32'd1);
        pulse_done();
        wait_grant(2, "t5_g2", n);
        pulse_done();
        wait_grant(2, "t5_g2b", n);

        // Asynchronous reset in the middle of a grant.
        do_reset(16'h0200, 16'h0);
        wait_grant(9, "t6_g9", n);
        @(negedge clk);
        req = 16'h0201;
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_gnt", 32'(gnt), 32'd0);
        chk("t6_async_vld", 32'(gnt_vld), 32'd0);
        chk("t6_async_to", 32'(timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant(0, "t6_g0", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb16.md
# rr_arb16

Sixteen-requester round-robin arbiter with grant hold, release handshake and hold-timeout, sharing one resource among up to 16 clients. It uses the lowest-index-first one-hot selector as its priority primitive: two instances, one on the rotated-priority request set and one on the full request set, give fair rotation. It sits between the requester bank and the shared datapath port. It drives a registered one-hot grant plus its encoded index.

## Interface
- HOLD_MAX, 255: maximum cycles one grant may be held before forced release; legal range 1..65535.
- CNT_W, $clog2(HOLD_MAX+1): hold counter width. Derived; do not override.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  16  per-requester request level.
- mask  in  16  per-requester disable; 1 excludes the requester from new arbitration.
- done  in  1  release pulse from the current grant holder.
- gnt  out  16  registered one-hot grant; all-zero when nothing is granted.
- gnt_vld  out  1  OR of gnt.
- gnt_idx  out  4  binary index of the granted bit; 0 when gnt_vld=0.
- timeout  out  1  one-cycle pulse on forced release.
- timeout_idx  out  4  index of the requester that was force-released; held until the next timeout.

## Operation
- Eligible set: elig = req & ~mask.
- Priority pointer ptr[3:0] holds the last granted index. Reset value 15, so index 0 has top priority after reset.
- Selection:
  - hi = elig & (bits strictly above ptr).
  - If hi≠0, winner = ffs(hi); else winner = ffs(elig).
  - ffs is the lowest-set-bit one-hot select.
- FSM states: IDLE, GRANT, RELEASE.
  - IDLE: if elig≠0, load gnt=winner, ptr=idx(winner), clear hold counter, go to GRANT. Otherwise stay.
  - GRANT: gnt is held and the hold counter increments each cycle, saturating at HOLD_MAX. Release when any of these holds:
    - (a) done=1;
    - (b) req[gnt_idx]=0;
    - (c) counter==HOLD_MAX-1 and neither (a) nor (b).
    - (c) sets timeout=1 for one cycle and timeout_idx=gnt_idx.
    - On release, clear gnt and go to RELEASE.
  - RELEASE: one bubble cycle with gnt=0, then IDLE. Arbitration is evaluated in IDLE only.
- Rules during a grant:
  - A mask change does not revoke an active grant; it affects only the next arbitration.
  - done while in IDLE or RELEASE is ignored.
  - (a) and (c) in the same cycle: treated as a normal release, no timeout.
- Reset at any point forces all of the following asynchronously, and the state becomes IDLE:
  - gnt=0, gnt_vld=0, gnt_idx=0;
  - timeout=0, timeout_idx=0;
  - ptr=15, counter=0.

## Timing
- Grant latency: elig first nonzero at edge t (state IDLE) → gnt valid after edge t+1.
- Release latency: release condition sampled at edge t → gnt=0 after edge t, RELEASE for one cycle. Earliest next grant is after edge t+2.
- Back-to-back grant period is therefore ≥3 cycles (1 grant + 1 bubble + 1 arbitration).
- Maximum hold without done is exactly HOLD_MAX cycles of gnt high.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package `arb_pkg`:
  - state encoding localparams (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - NREQ=16;
  - one-hot-to-index function onehot2idx16.
- Sub-module: the existing lowest-index-first one-hot selector `sixteen_ff`, instantiated twice (hi set, full elig set). No other sub-modules.
- Hold counter, pointer and FSM live in rr_arb16.

## Test plan
- Reset release with req=16'h8001, done pulsed each grant → grants in order: idx0, then idx15, then idx0. gnt one-hot; a 3-cycle period between grant edges.
- req=16'hFFFF, mask=0, done one cycle after each grant → gnt_idx sequence 0,1,2,…,15,0. Each index granted exactly once per 16 grants.
- Single requester req=16'h0010, never done, HOLD_MAX=4 → gnt=16'h0010 for exactly 4 cycles. Then timeout=1 for one cycle with timeout_idx=4, a bubble cycle, then regrant to idx4.
- Granted idx3 drops req[3] mid-grant while req[7]=1 → gnt clears next edge with no timeout; the next grant goes to idx7.
- req=16'h0006, mask=16'h0002 asserted during idx1 grant → idx1 keeps its grant until done. The next grant is idx2, and idx1 is not granted while masked.
- rst_n pulled low mid-GRANT at idx9 → gnt=0, timeout=0 immediately (asynchronous). After release with req=16'h0201, the first grant is idx0.
